// File: rtl/mealy_seq_detect.sv
// Parametrised Mealy serial pattern detector with run-time pattern reload,
// overlapping / non-overlapping modes and a saturating match counter.
module mealy_seq_detect #(
    parameter int unsigned      LEN     = 4,
    parameter logic [LEN-1:0]   PATTERN = 4'b1101,
    parameter int unsigned      OVERLAP = 1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             en,
    input  logic             load,
    input  logic [LEN-1:0]   pat_in,
    input  logic             clr_cnt,
    output logic             found,
    output logic             found_q,
    output logic [CNT_W-1:0] match_cnt,
    output logic [4:0]       state
);

    localparam int unsigned HW      = LEN + 1;
    localparam logic [4:0]  ST_IDLE = 5'd0;
    localparam logic [4:0]  ST_LAST = 5'(LEN - 1);

    logic [LEN-1:0]   pattern;
    logic [LEN-1:0]   pattern_d;
    logic [4:0]       state_d;
    logic [4:0]       fallback;
    logic [4:0]       shamt;
    logic [HW-1:0]    hist;
    logic [HW-1:0]    pfx;
    logic [HW-1:0]    msk;
    logic [CNT_W-1:0] cnt_d;

    assign found = en & ~load & (state == ST_LAST) & (x == pattern[0]);

    // History is implied by the state: the first 'state' pattern bits, then x.
    // Pick the longest suffix of it (capped at LEN-1) that is a pattern prefix.
    always_comb begin
        shamt    = 5'(LEN) - state;
        hist     = {pattern >> shamt, x};
        fallback = ST_IDLE;
        pfx      = '0;
        msk      = '0;
        for (int j = 1; j < int'(LEN); j++) begin
            pfx = HW'(pattern >> (int'(LEN) - j));
            msk = HW'((1 << j) - 1);
            if ((5'(j) <= state + 5'd1) && ((hist & msk) == pfx)) begin
                fallback = 5'(j);
            end
        end
    end

    // Next-state, pattern and counter selection.
    always_comb begin
        state_d   = state;
        pattern_d = pattern;
        cnt_d     = match_cnt;
        if (load) begin
            pattern_d = pat_in;
            state_d   = ST_IDLE;
        end else if (en) begin
            state_d = (found && (OVERLAP == 0)) ? ST_IDLE : fallback;
        end
        if (clr_cnt) begin
            cnt_d = '0;
        end else if (found && (match_cnt != '1)) begin
            cnt_d = match_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= ST_IDLE;
            pattern   <= PATTERN;
            match_cnt <= '0;
            found_q   <= 1'b0;
        end else begin
            state     <= state_d;
            pattern   <= pattern_d;
            match_cnt <= cnt_d;
            found_q   <= found;
        end
    end

endmodule

// File: tb/tb_mealy_seq_detect.sv
// Directed bench for mealy_seq_detect: overlapping, non-overlapping and
// 2-bit-counter instances share one stimulus stream.
module tb_mealy_seq_detect;

    logic       clk = 1'b0;
    logic       reset;
    logic       x;
    logic       en;
    logic       load;
    logic       clr_cnt;
    logic [3:0] pat_in;

    logic       f_ov, fq_ov, f_no, fq_no, f_c2, fq_c2;
    logic [7:0] cnt_ov, cnt_no;
    logic [1:0] cnt_c2;
    logic [4:0] st_ov, st_no, st_c2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mealy_seq_detect #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(1), .CNT_W(8)) dut_ov (
        .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .found(f_ov), .found_q(fq_ov), .match_cnt(cnt_ov), .state(st_ov));

    mealy_seq_detect #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(8)) dut_no (
        .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .found(f_no), .found_q(fq_no), .match_cnt(cnt_no), .state(st_no));

    mealy_seq_detect #(.LEN(4), .PATTERN(4'b1101), .OVERLAP(0), .CNT_W(2)) dut_c2 (
        .clk(clk), .reset(reset), .x(x), .en(en), .load(load), .pat_in(pat_in),
        .clr_cnt(clr_cnt), .found(f_c2), .found_q(fq_c2), .match_cnt(cnt_c2), .state(st_c2));

    // Inputs change 1 time unit after a rising edge; found is sampled 2 units later.
    task automatic drive(input logic xv, input logic ev);
        x = xv; en = ev; load = 1'b0; clr_cnt = 1'b0;
        #2;
    endtask

    task automatic edge_t();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0; x = 1'b0; en = 1'b0; load = 1'b0; clr_cnt = 1'b0; pat_in = 4'b0000;
        edge_t();
        edge_t();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b0;
        x = 1'b1; en = 1'b1;
        #2;
        checks++; if (st_ov !== 5'd0) begin failures++; $display("FAIL reset_state_ov got=%0d exp=0", st_ov); end
        checks++; if (cnt_ov !== 8'd0) begin failures++; $display("FAIL reset_cnt_ov got=%0d exp=0", cnt_ov); end
        checks++; if (fq_ov !== 1'b0) begin failures++; $display("FAIL reset_found_q_ov got=%b exp=0", fq_ov); end
        checks++; if (f_ov !== 1'b0) begin failures++; $display("FAIL reset_found_ov got=%b exp=0", f_ov); end
        checks++; if (st_no !== 5'd0) begin failures++; $display("FAIL reset_state_no got=%0d exp=0", st_no); end
        checks++; if (cnt_c2 !== 2'd0) begin failures++; $display("FAIL reset_cnt_c2 got=%0d exp=0", cnt_c2); end
        checks++; if (fq_c2 !== 1'b0) begin failures++; $display("FAIL reset_found_q_c2 got=%b exp=0", fq_c2); end
        edge_t();
        reset = 1'b1;
    endtask

    task automatic test_overlap();
        logic s[7]      = '{1, 1, 0, 1, 1, 0, 1};
        logic ef[7]     = '{0, 0, 0, 1, 0, 0, 1};
        logic [4:0] es[7] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(s[i], 1'b1);
            checks++; if (f_ov !== ef[i]) begin failures++; $display("FAIL ov_found bit=%0d got=%b exp=%b", i + 1, f_ov, ef[i]); end
            edge_t();
            checks++; if (st_ov !== es[i]) begin failures++; $display("FAIL ov_state bit=%0d got=%0d exp=%0d", i + 1, st_ov, es[i]); end
            checks++; if (fq_ov !== ef[i]) begin failures++; $display("FAIL ov_found_q bit=%0d got=%b exp=%b", i + 1, fq_ov, ef[i]); end
        end
        checks++; if (cnt_ov !== 8'd2) begin failures++; $display("FAIL ov_cnt got=%0d exp=2", cnt_ov); end
    endtask

    task automatic test_non_overlap();
        logic s[7]      = '{1, 1, 0, 1, 1, 0, 1};
        logic ef[7]     = '{0, 0, 0, 1, 0, 0, 0};
        logic [4:0] es[7] = '{5'd1, 5'd2, 5'd3, 5'd0, 5'd1, 5'd0, 5'd1};
        do_reset();
        for (int i = 0; i < 7; i++) begin
            drive(s[i], 1'b1);
            checks++; if (f_no !== ef[i]) begin failures++; $display("FAIL no_found bit=%0d got=%b exp=%b", i + 1, f_no, ef[i]); end
            edge_t();
            checks++; if (st_no !== es[i]) begin failures++; $display("FAIL no_state bit=%0d got=%0d exp=%0d", i + 1, st_no, es[i]); end
        end
        checks++; if (cnt_no !== 8'd1) begin failures++; $display("FAIL no_cnt got=%0d exp=1", cnt_no); end
    endtask

    task automatic test_enable_gap();
        do_reset();
        drive(1'b1, 1'b1); edge_t();
        drive(1'b1, 1'b1); edge_t();
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? 1'b0 : 1'b1, 1'b0);
            checks++; if (f_ov !== 1'b0) begin failures++; $display("FAIL gap_found cyc=%0d got=%b exp=0", i, f_ov); end
            edge_t();
            checks++; if (st_ov !== 5'd2) begin failures++; $display("FAIL gap_state cyc=%0d got=%0d exp=2", i, st_ov); end
        end
        drive(1'b0, 1'b1);
        checks++; if (f_ov !== 1'b0) begin failures++; $display("FAIL gap_found_bit3 got=%b exp=0", f_ov); end
        edge_t();
        drive(1'b1, 1'b1);
        checks++; if (f_ov !== 1'b1) begin failures++; $display("FAIL gap_found_bit4 got=%b exp=1", f_ov); end
        edge_t();
        checks++; if (cnt_ov !== 8'd1) begin failures++; $display("FAIL gap_cnt got=%0d exp=1", cnt_ov); end
    endtask

    task automatic test_load();
        logic s[8]    = '{0, 1, 1, 0, 1, 1, 0, 1};
        logic ef_no[8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        logic ef_ov[8] = '{0, 0, 0, 1, 0, 0, 1, 0};
        do_reset();
        drive(1'b1, 1'b1); edge_t();
        drive(1'b1, 1'b1); edge_t();
        checks++; if (st_no !== 5'd2) begin failures++; $display("FAIL load_pre_state got=%0d exp=2", st_no); end
        x = 1'b1; en = 1'b1; load = 1'b1; pat_in = 4'b0110;
        #2;
        checks++; if (f_no !== 1'b0) begin failures++; $display("FAIL load_found got=%b exp=0", f_no); end
        edge_t();
        load = 1'b0;
        checks++; if (st_no !== 5'd0) begin failures++; $display("FAIL load_state_no got=%0d exp=0", st_no); end
        checks++; if (st_ov !== 5'd0) begin failures++; $display("FAIL load_state_ov got=%0d exp=0", st_ov); end
        for (int i = 0; i < 8; i++) begin
            drive(s[i], 1'b1);
            checks++; if (f_no !== ef_no[i]) begin failures++; $display("FAIL load_found_no bit=%0d got=%b exp=%b", i + 1, f_no, ef_no[i]); end
            checks++; if (f_ov !== ef_ov[i]) begin failures++; $display("FAIL load_found_ov bit=%0d got=%b exp=%b", i + 1, f_ov, ef_ov[i]); end
            edge_t();
        end
    endtask

    task automatic test_saturate();
        logic s[4] = '{1, 1, 0, 1};
        logic [1:0] ec[5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        do_reset();
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 4; i++) begin
                drive(s[i], 1'b1);
                edge_t();
            end
            checks++; if (cnt_c2 !== ec[r]) begin failures++; $display("FAIL sat_cnt match=%0d got=%0d exp=%0d", r + 1, cnt_c2, ec[r]); end
        end
        for (int i = 0; i < 3; i++) begin
            drive(s[i], 1'b1);
            edge_t();
        end
        x = 1'b1; en = 1'b1; load = 1'b0; clr_cnt = 1'b1;
        #2;
        checks++; if (f_c2 !== 1'b1) begin failures++; $display("FAIL clr_found got=%b exp=1", f_c2); end
        edge_t();
        clr_cnt = 1'b0;
        checks++; if (cnt_c2 !== 2'd0) begin failures++; $display("FAIL clr_cnt got=%0d exp=0", cnt_c2); end
    endtask

    task automatic test_reset_mid();
        logic s[4] = '{0, 1, 1, 0};
        do_reset();
        x = 1'b0; en = 1'b1; load = 1'b1; pat_in = 4'b0110;
        #2;
        edge_t();
        for (int i = 0; i < 4; i++) begin
            drive(s[i], 1'b1);
            edge_t();
        end
        checks++; if (fq_ov !== 1'b1) begin failures++; $display("FAIL mid_pre_found_q got=%b exp=1", fq_ov); end
        checks++; if (cnt_ov !== 8'd1) begin failures++; $display("FAIL mid_pre_cnt got=%0d exp=1", cnt_ov); end
        x = 1'b1; en = 1'b1;
        reset = 1'b0;
        #1;
        checks++; if (st_ov !== 5'd0) begin failures++; $display("FAIL mid_state got=%0d exp=0", st_ov); end
        checks++; if (cnt_ov !== 8'd0) begin failures++; $display("FAIL mid_cnt got=%0d exp=0", cnt_ov); end
        checks++; if (fq_ov !== 1'b0) begin failures++; $display("FAIL mid_found_q got=%b exp=0", fq_ov); end
        edge_t();
        reset = 1'b1;
        drive(1'b1, 1'b1);
        checks++; if (f_ov !== 1'b0) begin failures++; $display("FAIL mid_first_bit_found got=%b exp=0", f_ov); end
        edge_t();
        drive(1'b1, 1'b1); edge_t();
        drive(1'b0, 1'b1); edge_t();
        drive(1'b1, 1'b1);
        checks++; if (f_ov !== 1'b1) begin failures++; $display("FAIL mid_revert_found got=%b exp=1", f_ov); end
        edge_t();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_overlap();
        test_non_overlap();
        test_enable_gap();
        test_load();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
